brq_mem_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the core's instruction-fetch port and its load/store port.
- Arbitrates each cycle and issues at most one access per cycle to the memory.
- Tracks the one-cycle read latency and steers response data back to the port that owns the access.
- Sits between the Buraq-mini core top level and a unified BRAM on the Arty A7; drives a fetch-stall indication back to the core.

---
 rtl/brq_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_brq_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/brq_mem_arbiter.sv
// Shares one single-port synchronous memory between the fetch and load/store ports.
// Optional macro ARB_RR_EN selects round-robin arbitration instead of data priority with a starvation limit.
module brq_mem_arbiter #(
  parameter int DataWidth   = 32,
  parameter int AddrWidth   = 15,
  parameter int StarveLimit = 4
) (
  input  logic                   brq_clk,
  input  logic                   brq_rst,
  input  logic                   inst_req,
  input  logic [AddrWidth-1:0]   inst_addr,
  output logic                   inst_gnt,
  output logic                   inst_rvalid,
  output logic [DataWidth-1:0]   inst_rdata,
  input  logic                   data_req,
  input  logic                   data_we,
  input  logic [AddrWidth-1:0]   data_addr,
  input  logic [DataWidth-1:0]   data_wdata,
  input  logic [DataWidth/8-1:0] data_be,
  output logic                   data_gnt,
  output logic                   data_rvalid,
  output logic [DataWidth-1:0]   data_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [AddrWidth-1:0]   mem_addr,
  output logic [DataWidth-1:0]   mem_wdata,
  output logic [DataWidth/8-1:0] mem_be,
  input  logic [DataWidth-1:0]   mem_rdata,
  output logic                   arb_stall
);

  localparam int BeW = DataWidth / 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DRD  = 2'd2,
    OWN_DWR  = 2'd3
  } owner_e;

  logic   w_prefer_inst;
  logic   w_inst_gnt;
  logic   w_data_gnt;
  owner_e r_owner;
  owner_e w_owner_nxt;

`ifdef ARB_RR_EN
  logic r_last_inst;

  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      r_last_inst <= 1'b1;
    end else if (w_inst_gnt) begin
      r_last_inst <= 1'b1;
    end else if (w_data_gnt) begin
      r_last_inst <= 1'b0;
    end
  end

  assign w_prefer_inst = ~r_last_inst;
`else
  localparam logic [3:0] StarveMax = 4'(StarveLimit);

  logic [3:0] r_starve_cnt;

  // Counts data grants that overtook a waiting fetch; saturates at the limit.
  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      r_starve_cnt <= 4'd0;
    end else if (!inst_req || w_inst_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (w_data_gnt && (r_starve_cnt != StarveMax)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  assign w_prefer_inst = (r_starve_cnt == StarveMax);
`endif

  // Grants are gated by reset so every output is quiet while it is held.
  assign w_inst_gnt = brq_rst & inst_req & (~data_req | w_prefer_inst);
  assign w_data_gnt = brq_rst & data_req & (~inst_req | ~w_prefer_inst);

  assign inst_gnt  = w_inst_gnt;
  assign data_gnt  = w_data_gnt;
  assign mem_en    = w_inst_gnt | w_data_gnt;
  assign arb_stall = brq_rst & inst_req & ~w_inst_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (w_inst_gnt) begin
      mem_addr = inst_addr;
    end else if (w_data_gnt) begin
      mem_we    = data_we;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
      mem_be    = data_be[BeW-1:0];
    end
  end

  // Response owner: records who holds the access whose data returns next cycle.
  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_inst_gnt) begin
      w_owner_nxt = OWN_INST;
    end else if (w_data_gnt) begin
      w_owner_nxt = data_we ? OWN_DWR : OWN_DRD;
    end
  end

  always_comb begin
    inst_rvalid = 1'b0;
    inst_rdata  = '0;
    data_rvalid = 1'b0;
    data_rdata  = '0;
    case (r_owner)
      OWN_INST: begin
        inst_rvalid = 1'b1;
        inst_rdata  = mem_rdata;
      end
      OWN_DRD: begin
        data_rvalid = 1'b1;
        data_rdata  = mem_rdata;
      end
      OWN_DWR: begin
        data_rvalid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_brq_mem_arbiter.sv
// Directed self-checking bench for brq_mem_arbiter (default parameters).
module tb_brq_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 15;

  logic          brq_clk = 1'b0;
  logic          brq_rst;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_gnt;
  logic          inst_rvalid;
  logic [DW-1:0] inst_rdata;
  logic          data_req;
  logic          data_we;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [3:0]    data_be;
  logic          data_gnt;
  logic          data_rvalid;
  logic [DW-1:0] data_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_rdata;
  logic          arb_stall;

  int n_cmp  = 0;
  int n_fail = 0;

  brq_mem_arbiter #(.DataWidth(DW), .AddrWidth(AW), .StarveLimit(4)) dut (
    .brq_clk(brq_clk), .brq_rst(brq_rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_be(data_be), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .arb_stall(arb_stall)
  );

  always #5 brq_clk = ~brq_clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge brq_clk);
    #1;
  endtask

  task automatic test_reset();
    brq_rst = 1'b0; inst_req = 1'b1; inst_addr = 15'h0010;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_be = '0;
    mem_rdata = 32'h0000_0013;
    next_cycle();
    next_cycle();
    n_cmp++;
    if ({inst_gnt, data_gnt, mem_en, arb_stall, inst_rvalid, data_rvalid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt/en/stall/rvalid=%b required 000000",
               {inst_gnt, data_gnt, mem_en, arb_stall, inst_rvalid, data_rvalid});
    end
    n_cmp++;
    if ({mem_addr, inst_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_buses: mem_addr=%h inst_rdata=%h required 0", mem_addr, inst_rdata);
    end
    brq_rst = 1'b1;
    #1;
    n_cmp++;
    if ({inst_gnt, mem_en, mem_we, arb_stall, data_gnt} !== 5'b11000) begin
      n_fail++;
      $display("FAIL first_fetch_gnt: gnt/en/we/stall/dgnt=%b required 11000",
               {inst_gnt, mem_en, mem_we, arb_stall, data_gnt});
    end
    n_cmp++;
    if (mem_addr !== 15'h0010) begin
      n_fail++;
      $display("FAIL first_fetch_addr: mem_addr=%h required 0010", mem_addr);
    end
    next_cycle();
    inst_req = 1'b0;
    #1;
    n_cmp++;
    if ({inst_rvalid, arb_stall, inst_gnt, data_rvalid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL first_fetch_rvalid: rvalid/stall/gnt/drvalid=%b required 1000",
               {inst_rvalid, arb_stall, inst_gnt, data_rvalid});
    end
    n_cmp++;
    if (inst_rdata !== 32'h0000_0013) begin
      n_fail++;
      $display("FAIL first_fetch_rdata: inst_rdata=%h required 00000013", inst_rdata);
    end
  endtask

  task automatic test_starvation();
    logic exp_d [10];
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_RR_EN
      exp_d[i] = (i % 2) == 0;
`else
      exp_d[i] = (i % 5) != 4;
`endif
    end
    next_cycle();
    inst_req = 1'b1; inst_addr = 15'h0040;
    data_req = 1'b1; data_we = 1'b0; data_addr = 15'h0100;
    data_wdata = 32'hFFFF_FFFF; data_be = 4'hF; mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if ({data_gnt, inst_gnt, arb_stall} !== {exp_d[i], ~exp_d[i], exp_d[i]}) begin
        n_fail++;
        $display("FAIL starve_grant[%0d]: dgnt/ignt/stall=%b required %b", i,
                 {data_gnt, inst_gnt, arb_stall}, {exp_d[i], ~exp_d[i], exp_d[i]});
      end
      if (!exp_d[i]) begin
        n_cmp++;
        if ({mem_addr, mem_we, mem_be, mem_wdata} !== {15'h0040, 1'b0, 4'h0, 32'h0}) begin
          n_fail++;
          $display("FAIL starve_fetch_mux[%0d]: addr=%h we=%b be=%h wdata=%h required 0040/0/0/0",
                   i, mem_addr, mem_we, mem_be, mem_wdata);
        end
      end
      if (i > 0) begin
        n_cmp++;
        if ({inst_rvalid, data_rvalid} !== {~exp_d[i-1], exp_d[i-1]}) begin
          n_fail++;
          $display("FAIL starve_rvalid[%0d]: irv/drv=%b required %b", i,
                   {inst_rvalid, data_rvalid}, {~exp_d[i-1], exp_d[i-1]});
        end
      end
      next_cycle();
    end
    inst_req = 1'b0; data_req = 1'b0;
    #1;
    n_cmp++;
    if ({inst_rvalid, data_rvalid, inst_rdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL starve_last_rsp: irv=%b drv=%b irdata=%h required 1/0/12345678",
               inst_rvalid, data_rvalid, inst_rdata);
    end
  endtask

  task automatic test_store();
    next_cycle();
    data_req = 1'b1; data_we = 1'b1; data_addr = 15'h0200;
    data_wdata = 32'hDEAD_BEEF; data_be = 4'b0011; mem_rdata = 32'h5555_5555;
    #1;
    n_cmp++;
    if ({data_gnt, mem_en, mem_we, mem_be, arb_stall} !== {1'b1, 1'b1, 1'b1, 4'b0011, 1'b0}) begin
      n_fail++;
      $display("FAIL store_ctrl: gnt/en/we/be/stall=%b required 11100110",
               {data_gnt, mem_en, mem_we, mem_be, arb_stall});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata} !== {15'h0200, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL store_bus: addr=%h wdata=%h required 0200/deadbeef", mem_addr, mem_wdata);
    end
    next_cycle();
    data_req = 1'b0; data_we = 1'b0;
    #1;
    n_cmp++;
    if ({data_rvalid, inst_rvalid, data_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL store_ack: drv=%b irv=%b drdata=%h required 1/0/00000000",
               data_rvalid, inst_rvalid, data_rdata);
    end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    data_req = 1'b1; data_we = 1'b0; data_addr = 15'h0001; mem_rdata = 32'h0;
    #1;
    n_cmp++;
    if ({data_gnt, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 15'h0001}) begin
      n_fail++;
      $display("FAIL b2b_gnt0: gnt=%b en=%b we=%b addr=%h required 1/1/0/0001",
               data_gnt, mem_en, mem_we, mem_addr);
    end
    next_cycle();
    data_addr = 15'h0002; mem_rdata = 32'h0000_000A;
    #1;
    n_cmp++;
    if ({data_gnt, mem_addr, data_rvalid, data_rdata} !== {1'b1, 15'h0002, 1'b1, 32'hA}) begin
      n_fail++;
      $display("FAIL b2b_rsp0: gnt=%b addr=%h drv=%b drdata=%h required 1/0002/1/0000000a",
               data_gnt, mem_addr, data_rvalid, data_rdata);
    end
    next_cycle();
    data_req = 1'b0; mem_rdata = 32'h0000_000B;
    #1;
    n_cmp++;
    if ({mem_en, data_rvalid, data_rdata} !== {1'b0, 1'b1, 32'hB}) begin
      n_fail++;
      $display("FAIL b2b_rsp1: en=%b drv=%b drdata=%h required 0/1/0000000b",
               mem_en, data_rvalid, data_rdata);
    end
    next_cycle();
    #1;
    n_cmp++;
    if ({data_rvalid, data_rdata} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL b2b_idle: drv=%b drdata=%h required 0/00000000", data_rvalid, data_rdata);
    end
  endtask

  task automatic test_reset_midflight();
    next_cycle();
    inst_req = 1'b1; inst_addr = 15'h0020; mem_rdata = 32'h7777_7777;
    #1;
    n_cmp++;
    if ({inst_gnt, mem_addr} !== {1'b1, 15'h0020}) begin
      n_fail++;
      $display("FAIL midrst_gnt: gnt=%b addr=%h required 1/0020", inst_gnt, mem_addr);
    end
    next_cycle();
    brq_rst = 1'b0; inst_req = 1'b0;
    #1;
    n_cmp++;
    if ({inst_rvalid, inst_rdata} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL midrst_discard: irv=%b irdata=%h required 0/00000000", inst_rvalid, inst_rdata);
    end
    next_cycle();
    brq_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({inst_rvalid, data_rvalid, inst_gnt, data_gnt, mem_en, arb_stall, inst_rdata, data_rdata}
          !== {6'b0, 64'h0}) begin
        n_fail++;
        $display("FAIL midrst_quiet[%0d]: irv=%b drv=%b en=%b stall=%b irdata=%h required all 0",
                 i, inst_rvalid, data_rvalid, mem_en, arb_stall, inst_rdata);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_starvation();
    test_store();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
